// File: rtl/vga_stream_pkg.sv
// Shared constants for the VGA pixel stream: frame geometry, pixel width and RGB444 layout.
// Reused by the VGA wrapper, the framebuffer writer and the frame streamer.
package vga_stream_pkg;

  localparam int DATA_W    = 12;
  localparam int H_PIX     = 160;
  localparam int V_PIX     = 120;
  localparam int FRAME_PIX = H_PIX * V_PIX;
  localparam int ADDR_W    = 15;

  localparam int CH_W  = 4;
  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

  // Default-width stream word as it sits in the output buffer.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } pix_word_t;

endpackage

// File: rtl/vga_pix_fifo2.sv
// Two-entry register FIFO with the head entry held in a register, so consumers
// see no combinational path from the write side.
module vga_pix_fifo2 #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_count;

  // NOTE: the data registers are reset as well as the count, because the head
  // drives the pixel output directly and must read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments let r_head take the old r_tail in a
      // shift while r_tail is overwritten in the same edge.
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_din;
          else                 r_tail <= i_din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= i_din;
          end else begin
            r_head <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/vga_frame_streamer.sv
// Raster-order pixel source: reads the framebuffer with 1-cycle latency and feeds a
// ready-only VGA sink through a 2-entry buffer, tagging start/end of frame.
module vga_frame_streamer
  import vga_stream_pkg::*;
#(
  parameter int H_PIX  = vga_stream_pkg::H_PIX,
  parameter int V_PIX  = vga_stream_pkg::V_PIX,
  parameter int ADDR_W = vga_stream_pkg::ADDR_W,
  parameter int DATA_W = vga_stream_pkg::DATA_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [DATA_W-1:0] fb_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_sop,
  output logic              pix_eop,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam int                FRAME    = H_PIX * V_PIX;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME - 1);

  logic [ADDR_W-1:0] r_index;
  logic              r_inflight;
  logic              r_tag_sop;
  logic              r_tag_eop;
  logic              r_underrun;
  logic              r_frame_done;

  logic [DATA_W+1:0] w_head;
  logic [1:0]        w_count;
  logic              w_valid;
  logic              w_pop;
  logic [2:0]        w_level;
  logic              w_issue;

  assign w_valid = (w_count != 2'd0);
  assign w_pop   = pix_ready & w_valid;

  // Words owed to the buffer after this cycle; never let it exceed two.
  assign w_level = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue = reset_reset_n & (w_level < 3'd2);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_index      <= '0;
      r_inflight   <= 1'b0;
      r_tag_sop    <= 1'b0;
      r_tag_eop    <= 1'b0;
      r_underrun   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_issue) begin
        r_index <= (r_index == LAST_IDX) ? '0 : r_index + ADDR_W'(1);
      end
      r_inflight   <= w_issue;
      r_tag_sop    <= w_issue & (r_index == '0);
      r_tag_eop    <= w_issue & (r_index == LAST_IDX);
      // Set wins over clear: a garbage consume is never silently lost.
      r_underrun   <= (pix_ready & ~w_valid) | (r_underrun & ~underrun_clr);
      r_frame_done <= w_pop & w_head[0];
    end
  end

  vga_pix_fifo2 #(
    .W (DATA_W + 2)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_push  (r_inflight),
    .i_din   ({fb_rdata, r_tag_sop, r_tag_eop}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign fb_addr    = r_index;
  assign fb_rd      = w_issue;
  assign pix_data   = w_head[DATA_W+1:2];
  assign pix_sop    = w_head[1];
  assign pix_eop    = w_head[0];
  assign pix_valid  = w_valid;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

endmodule
